// File: rtl/cdc_reg_responder.sv
// Command parser behind the USB CDC byte stream: 'W' addr data / 'R' addr / other -> one-byte reply.
// Optional build macro CDC_REG_TIMEOUT_EN aborts a half-received command after TIMEOUT_CYCLES idle cycles.
module cdc_reg_responder #(
  parameter int unsigned NUM_REGS       = 4,
  parameter logic [7:0]  STATUS_ADDR    = 8'h80,
  parameter int unsigned TIMEOUT_CYCLES = 48000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  configured_i,
  input  logic [7:0]            out_data_i,
  input  logic                  out_valid_i,
  output logic                  out_ready_o,
  output logic [7:0]            in_data_o,
  output logic                  in_valid_o,
  input  logic                  in_ready_i,
  input  logic [7:0]            status_i,
  output logic [8*NUM_REGS-1:0] regs_o
);

  localparam int unsigned IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0]  NUM_REGS_B = 8'(NUM_REGS);
  localparam logic [7:0]  OP_WRITE   = 8'h57;
  localparam logic [7:0]  OP_READ    = 8'h52;
  localparam logic [7:0]  RSP_OK     = 8'h4B;
  localparam logic [7:0]  RSP_ERR    = 8'h45;

  typedef enum logic [2:0] {IDLE, W_ADDR, W_DATA, R_ADDR, RESP} state_t;

  state_t           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       in_data_d;
  logic             in_valid_d, out_ready_d;
  logic [7:0]       regs_q [NUM_REGS];
  logic             wr_en;
  logic [7:0]       rd_data;
  logic             out_fire, in_fire, timeout;

  assign out_fire = out_valid_i && out_ready_o;
  assign in_fire  = in_valid_o && in_ready_i;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_pack
    assign regs_o[8*k +: 8] = regs_q[k];
  end

  // Read value for the address byte currently on the OUT stream; registers win over status.
  always_comb begin
    rd_data = RSP_ERR;
    if (out_data_i < NUM_REGS_B)
      rd_data = regs_q[out_data_i[IDX_W-1:0]];
    else if (out_data_i == STATUS_ADDR)
      rd_data = status_i;
  end

`ifdef CDC_REG_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt_q;
  logic             parsing;

  assign parsing = (state_q == W_ADDR) || (state_q == W_DATA) || (state_q == R_ADDR);
  assign timeout = parsing && (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Entering a parse state always comes from IDLE or an accepted byte, so both clear here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_cnt_q <= '0;
    else if (!parsing || out_fire)
      idle_cnt_q <= '0;
    else if (!timeout)
      idle_cnt_q <= idle_cnt_q + CNT_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no path leaves a value unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    in_data_d   = in_data_o;
    in_valid_d  = in_valid_o;
    out_ready_d = out_ready_o;
    wr_en       = 1'b0;

    if (!configured_i) begin
      // Unconfigured: swallow OUT bytes and drop any pending reply; registers are untouched.
      state_d     = IDLE;
      in_valid_d  = 1'b0;
      out_ready_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          out_ready_d = 1'b1;
          if (out_fire) begin
            if (out_data_i == OP_WRITE)
              state_d = W_ADDR;
            else if (out_data_i == OP_READ)
              state_d = R_ADDR;
            else begin
              in_data_d   = RSP_ERR;
              in_valid_d  = 1'b1;
              out_ready_d = 1'b0;
              state_d     = RESP;
            end
          end
        end
        W_ADDR: begin
          out_ready_d = 1'b1;
          if (out_fire) begin
            addr_d  = out_data_i;
            state_d = W_DATA;
          end else if (timeout)
            state_d = IDLE;
        end
        W_DATA: begin
          out_ready_d = 1'b1;
          if (out_fire) begin
            wr_en       = (addr_q < NUM_REGS_B);
            in_data_d   = (addr_q < NUM_REGS_B) ? RSP_OK : RSP_ERR;
            in_valid_d  = 1'b1;
            out_ready_d = 1'b0;
            state_d     = RESP;
          end else if (timeout)
            state_d = IDLE;
        end
        R_ADDR: begin
          out_ready_d = 1'b1;
          if (out_fire) begin
            in_data_d   = rd_data;
            in_valid_d  = 1'b1;
            out_ready_d = 1'b0;
            state_d     = RESP;
          end else if (timeout)
            state_d = IDLE;
        end
        RESP: begin
          out_ready_d = 1'b0;
          in_valid_d  = 1'b1;
          if (in_fire) begin
            in_valid_d  = 1'b0;
            out_ready_d = 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      in_data_o   <= '0;
      in_valid_o  <= 1'b0;
      out_ready_o <= 1'b0;
      // NOTE: this register file is reset because the host relies on known control values;
      // a plain data memory would normally be left unreset.
      for (int k = 0; k < NUM_REGS; k++)
        regs_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      in_data_o   <= in_data_d;
      in_valid_o  <= in_valid_d;
      out_ready_o <= out_ready_d;
      if (wr_en)
        regs_q[addr_q[IDX_W-1:0]] <= out_data_i;
    end
  end

endmodule

// File: tb/tb_cdc_reg_responder.sv
// Directed testbench for cdc_reg_responder (NUM_REGS=4, STATUS_ADDR=0x80, TIMEOUT_CYCLES=16).
module tb_cdc_reg_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        configured_i;
  logic [7:0]  out_data_i;
  logic        out_valid_i;
  logic        out_ready_o;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready_i;
  logic [7:0]  status_i;
  logic [31:0] regs_o;

  int tests = 0;
  int fails = 0;
  int in_count = 0;

  cdc_reg_responder #(
    .NUM_REGS      (4),
    .STATUS_ADDR   (8'h80),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .configured_i(configured_i),
    .out_data_i  (out_data_i),
    .out_valid_i (out_valid_i),
    .out_ready_o (out_ready_o),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i),
    .status_i    (status_i),
    .regs_o      (regs_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (in_valid_o && in_ready_i) in_count++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called #1 after a posedge; returns #1 after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    out_data_i  = b;
    out_valid_i = 1'b1;
    while (out_ready_o !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (out_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL send_byte: out_ready_o=%b never 1 for byte %h", out_ready_o, b);
    end
    @(posedge clk); #1;
    out_valid_i = 1'b0;
  endtask

  // Waits (bounded) for a response byte; if in_ready_i is high, also lets the transfer edge pass.
  task automatic get_resp(output logic [7:0] data, output bit ok);
    int n = 0;
    while (in_valid_o !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ok   = (in_valid_o === 1'b1);
    data = in_data_o;
    if (ok && in_ready_i === 1'b1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; configured_i = 1'b1; out_data_i = 8'h00; out_valid_i = 1'b0;
    in_ready_i = 1'b1; status_i = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (regs_o !== 32'h0 || in_data_o !== 8'h00 || in_valid_o !== 1'b0 || out_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: regs=%h in_data=%h in_valid=%b out_ready=%b want 0/0/0/0",
               regs_o, in_data_o, in_valid_o, out_ready_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_rise: out_ready_o=%b want 1", out_ready_o);
    end
  endtask

  task automatic test_write();
    logic [7:0] d; bit ok; int c0;
    c0 = in_count;
    send_byte(8'h57); send_byte(8'h02); send_byte(8'hA5);
    tests++;
    if (regs_o !== 32'h00A5_0000) begin
      fails++;
      $display("FAIL write_reg2: regs_o=%h want 00a50000", regs_o);
    end
    get_resp(d, ok);
    tests++;
    if (!ok || d !== 8'h4B) begin
      fails++;
      $display("FAIL write_resp: got %h valid=%0d want 4b", d, ok);
    end
    tests++;
    if (in_count - c0 != 1 || out_ready_o !== 1'b1) begin
      fail_line("write_one_xfer", in_count - c0, out_ready_o);
    end
  endtask

  task automatic fail_line(input string name, input int xfers, input logic rdy);
    fails++;
    $display("FAIL %s: transfers=%0d out_ready=%b want 1/1", name, xfers, rdy);
  endtask

  task automatic test_read();
    logic [7:0] d; bit ok;
    send_byte(8'h52); send_byte(8'h02);
    get_resp(d, ok);
    tests++;
    if (!ok || d !== 8'hA5) begin
      fails++;
      $display("FAIL read_reg2: got %h valid=%0d want a5", d, ok);
    end
    status_i = 8'h3C;
    send_byte(8'h52); send_byte(8'h80);
    get_resp(d, ok);
    tests++;
    if (!ok || d !== 8'h3C) begin
      fails++;
      $display("FAIL read_status: got %h valid=%0d want 3c", d, ok);
    end
    send_byte(8'h52); send_byte(8'h03);
    get_resp(d, ok);
    tests++;
    if (!ok || d !== 8'h00) begin
      fails++;
      $display("FAIL read_reg3: got %h valid=%0d want 00", d, ok);
    end
  endtask

  task automatic test_bad();
    logic [7:0] d; bit ok;
    send_byte(8'h57); send_byte(8'h07); send_byte(8'h11);
    get_resp(d, ok);
    tests++;
    if (!ok || d !== 8'h45 || regs_o !== 32'h00A5_0000) begin
      fails++;
      $display("FAIL write_bad_addr: got %h regs=%h want 45 / 00a50000", d, regs_o);
    end
    send_byte(8'h57); send_byte(8'h04); send_byte(8'h11);
    get_resp(d, ok);
    tests++;
    if (!ok || d !== 8'h45 || regs_o !== 32'h00A5_0000) begin
      fails++;
      $display("FAIL write_addr4: got %h regs=%h want 45 / 00a50000", d, regs_o);
    end
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hC3);
    get_resp(d, ok);
    tests++;
    if (!ok || d !== 8'h4B || regs_o !== 32'hC3A5_0000) begin
      fails++;
      $display("FAIL write_addr3: got %h regs=%h want 4b / c3a50000", d, regs_o);
    end
    send_byte(8'h41);
    tests++;
    if (in_valid_o !== 1'b1 || in_data_o !== 8'h45 || out_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL bad_opcode: in_valid=%b in_data=%h out_ready=%b want 1/45/0",
               in_valid_o, in_data_o, out_ready_o);
    end
    @(posedge clk); #1;
    send_byte(8'h52); send_byte(8'h05);
    get_resp(d, ok);
    tests++;
    if (!ok || d !== 8'h45) begin
      fails++;
      $display("FAIL read_bad_addr: got %h valid=%0d want 45", d, ok);
    end
  endtask

  task automatic test_back_pressure();
    int c0;
    in_ready_i = 1'b0;
    send_byte(8'h52); send_byte(8'h02);
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (in_valid_o !== 1'b1 || in_data_o !== 8'hA5 || out_ready_o !== 1'b0) begin
        fails++;
        $display("FAIL hold_cycle%0d: in_valid=%b in_data=%h out_ready=%b want 1/a5/0",
                 i, in_valid_o, in_data_o, out_ready_o);
      end
      @(posedge clk); #1;
    end
    c0 = in_count;
    in_ready_i = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_count - c0 != 1 || in_valid_o !== 1'b0 || out_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL release: transfers=%0d in_valid=%b out_ready=%b want 1/0/1",
               in_count - c0, in_valid_o, out_ready_o);
    end
  endtask

  task automatic test_unconfigured();
    logic [7:0] d; bit ok; int c0;
    in_ready_i = 1'b0;
    send_byte(8'h52); send_byte(8'h00);
    configured_i = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (in_valid_o !== 1'b0 || out_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL unconf_drop: in_valid=%b out_ready=%b want 0/1", in_valid_o, out_ready_o);
    end
    c0 = in_count;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'hFF);
    @(posedge clk); #1;
    tests++;
    if (regs_o !== 32'hC3A5_0000 || in_valid_o !== 1'b0 || in_count != c0) begin
      fails++;
      $display("FAIL unconf_ignore: regs=%h in_valid=%b xfers=%0d want c3a50000/0/0",
               regs_o, in_valid_o, in_count - c0);
    end
    configured_i = 1'b1;
    in_ready_i   = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h52); send_byte(8'h00);
    get_resp(d, ok);
    tests++;
    if (!ok || d !== 8'h00) begin
      fails++;
      $display("FAIL reconf_read: got %h valid=%0d want 00", d, ok);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] d; bit ok; int c0;
    logic [7:0] exp;
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h3E);
    get_resp(d, ok);
    tests++;
    if (!ok || d !== 8'h4B || regs_o !== 32'hC3A5_3E00) begin
      fails++;
      $display("FAIL write_reg1: got %h regs=%h want 4b / c3a53e00", d, regs_o);
    end
`ifdef CDC_REG_TIMEOUT_EN
    exp = 8'h3E;
`else
    exp = 8'h45;
`endif
    c0 = in_count;
    send_byte(8'h57);
    repeat (17) @(posedge clk);
    #1;
    send_byte(8'h52); send_byte(8'h01);
    get_resp(d, ok);
    tests++;
    if (!ok || d !== exp || in_count - c0 != 1 || regs_o !== 32'hC3A5_3E00) begin
      fails++;
      $display("FAIL stall_sequence: got %h xfers=%0d regs=%h want %h / 1 / c3a53e00",
               d, in_count - c0, regs_o, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; bit ok;
    send_byte(8'h57); send_byte(8'h01);
    rst_n = 1'b0;
    #1;
    tests++;
    if (regs_o !== 32'h0 || in_valid_o !== 1'b0 || out_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: regs=%h in_valid=%b out_ready=%b want 0/0/0",
               regs_o, in_valid_o, out_ready_o);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h52); send_byte(8'h01);
    get_resp(d, ok);
    tests++;
    if (!ok || d !== 8'h00) begin
      fails++;
      $display("FAIL post_reset_read: got %h valid=%0d want 00", d, ok);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad();
    test_back_pressure();
    test_unconfigured();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
